// File: rtl/life_grid_engine.sv
// -----------------------------------------------------------------------------
// life_grid_engine
//
// Conway's Game of Life (B3/S23) engine for a ROWS x COLS grid. The whole next
// generation is computed combinationally and committed in a single COMPUTE
// cycle. Each generation is then streamed out serially, cell 0 first, over a
// ready/valid handshake. The grid doubles as the dump shift register: it
// rotates one cell per accepted transfer, so after N transfers it is back in
// its original order.
//
// Parameters
//   ROWS, COLS : grid size (3..16 each), N = ROWS*COLS cells, index r*COLS+c
//   WRAP       : 0 = off-grid cells are dead, 1 = toroidal neighbourhood
//   GEN_W      : width of the generation counter and target
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   load_en, load_bit     : serial grid load (IDLE only)
//   start, gen_target     : begin a run; target 0 = run until stable/extinct
//   out_ready             : consumer accepts out_bit
//   out_valid, out_bit    : serial dump of the last computed generation
//   busy                  : state is not IDLE
//   gen_count             : generations computed since the last start
//   stable, extinct       : last generation equals predecessor / is all dead
//   state                 : IDLE=00, COMPUTE=01, DUMP=10
// -----------------------------------------------------------------------------
module life_grid_engine #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int WRAP  = 0,
    parameter int GEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic             load_bit,
    input  logic             start,
    input  logic [GEN_W-1:0] gen_target,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
    output logic             stable,
    output logic             extinct,
    output logic [1:0]       state
);

    localparam int N     = ROWS * COLS;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COMPUTE = 2'b01,
        DUMP    = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [N-1:0]     grid;
    logic [N-1:0]     next_grid;
    logic [GEN_W-1:0] target_q;
    logic [CNT_W-1:0] dump_cnt;
    logic             last_transfer;
    logic             run_done;
    logic             gen_sat;

    // Per-cell neighbourhood. Each of the 9 taps of the 3x3 window resolves at
    // elaboration time to either a grid index or a constant 0 (the centre tap,
    // and off-grid taps when WRAP is 0), so no runtime modulo logic exists.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [8:0] nb;
            logic [3:0] cnt;

            for (genvar d = 0; d < 9; d++) begin : g_tap
                localparam int  RR     = r + d / 3 - 1;
                localparam int  CC     = c + d % 3 - 1;
                localparam int  RW     = (RR + ROWS) % ROWS;
                localparam int  CW     = (CC + COLS) % COLS;
                localparam bit  INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                localparam int  SRC    = (WRAP != 0) ? (RW * COLS + CW)
                                                     : (INSIDE ? (RR * COLS + CC) : -1);
                if ((d == 4) || (SRC < 0)) begin : g_zero
                    assign nb[d] = 1'b0;
                end else begin : g_live
                    assign nb[d] = grid[SRC];
                end
            end

            always_comb begin
                cnt = 4'd0;
                for (int i = 0; i < 9; i++) begin
                    cnt = cnt + {3'b000, nb[i]};
                end
            end

            // Birth on exactly 3, survival on 2 or 3.
            assign next_grid[r*COLS+c] = (cnt == 4'd3) || (grid[r*COLS+c] && (cnt == 4'd2));
        end
    end

    assign gen_sat       = &gen_count;
    assign last_transfer = out_ready && (dump_cnt == LAST_IDX);

    // A run ends on reaching the latched target, or, with a zero target, once
    // the pattern has settled or died. A saturated counter always ends it.
    assign run_done = gen_sat ||
                      ((target_q != '0) ? (gen_count == target_q) : (stable || extinct));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COMPUTE;
            COMPUTE: state_d = DUMP;
            DUMP:    if (last_transfer) state_d = run_done ? IDLE : COMPUTE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == DUMP);
        out_bit   = (state_q == DUMP) && grid[0];
        busy      = (state_q != IDLE);
        state     = state_q;
    end

    // Grid, counters and flags. In IDLE the grid is a load shift register
    // (start wins and drops a simultaneous load); in DUMP it rotates so cell 0
    // is always the bit on offer.
    always_ff @(posedge clock) begin
        if (reset) begin
            grid      <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
            extinct   <= 1'b0;
            target_q  <= '0;
            dump_cnt  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        target_q  <= gen_target;
                        gen_count <= '0;
                        stable    <= 1'b0;
                        extinct   <= 1'b0;
                    end else if (load_en) begin
                        grid <= {load_bit, grid[N-1:1]};
                    end
                end
                COMPUTE: begin
                    grid     <= next_grid;
                    stable   <= (next_grid == grid);
                    extinct  <= (next_grid == '0);
                    dump_cnt <= '0;
                    if (!gen_sat) begin
                        gen_count <= gen_count + GEN_W'(1);
                    end
                end
                DUMP: begin
                    if (out_ready) begin
                        grid     <= {grid[0], grid[N-1:1]};
                        dump_cnt <= last_transfer ? '0 : (dump_cnt + CNT_W'(1));
                    end
                end
                default: begin
                    dump_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_life_grid_engine.sv
// -----------------------------------------------------------------------------
// tb_life_grid_engine
//
// Four engine instances share one clock and reset:
//   unit 0: 5x5 WRAP=0   unit 1: 5x5 WRAP=1
//   unit 2: 4x6 WRAP=0   unit 3: 4x6 WRAP=1
// A table of hand-derived patterns is run first, then hand-written reset and
// randomized runs. Every dumped generation is compared against a reference
// Life model that counts neighbours with plain index arithmetic.
// -----------------------------------------------------------------------------
module tb_life_grid_engine;

    localparam int UNITS = 4;
    localparam int RUN_BUDGET = 20000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load_en    [UNITS];
    logic       load_bit   [UNITS];
    logic       start      [UNITS];
    logic [7:0] gen_target [UNITS];
    logic       out_ready  [UNITS];
    logic       out_valid  [UNITS];
    logic       out_bit    [UNITS];
    logic       busy       [UNITS];
    logic [7:0] gen_count  [UNITS];
    logic       stable     [UNITS];
    logic       extinct    [UNITS];
    logic [1:0] state      [UNITS];

    int checks = 0;
    int passed = 0;

    typedef struct {
        string      name;
        int         unit;
        bit [31:0]  init;
        logic [7:0] target;
        bit         stall;
        bit         load_with_start;
        bit [31:0]  exp_grid;
        logic [7:0] exp_gen;
        bit         exp_stable;
        bit         exp_extinct;
    } vec_t;

    always #5 clock = ~clock;

    life_grid_engine #(.ROWS(5), .COLS(5), .WRAP(0), .GEN_W(8)) dut0 (
        .clock(clock), .reset(reset), .load_en(load_en[0]), .load_bit(load_bit[0]),
        .start(start[0]), .gen_target(gen_target[0]), .out_ready(out_ready[0]),
        .out_valid(out_valid[0]), .out_bit(out_bit[0]), .busy(busy[0]),
        .gen_count(gen_count[0]), .stable(stable[0]), .extinct(extinct[0]), .state(state[0])
    );

    life_grid_engine #(.ROWS(5), .COLS(5), .WRAP(1), .GEN_W(8)) dut1 (
        .clock(clock), .reset(reset), .load_en(load_en[1]), .load_bit(load_bit[1]),
        .start(start[1]), .gen_target(gen_target[1]), .out_ready(out_ready[1]),
        .out_valid(out_valid[1]), .out_bit(out_bit[1]), .busy(busy[1]),
        .gen_count(gen_count[1]), .stable(stable[1]), .extinct(extinct[1]), .state(state[1])
    );

    life_grid_engine #(.ROWS(4), .COLS(6), .WRAP(0), .GEN_W(8)) dut2 (
        .clock(clock), .reset(reset), .load_en(load_en[2]), .load_bit(load_bit[2]),
        .start(start[2]), .gen_target(gen_target[2]), .out_ready(out_ready[2]),
        .out_valid(out_valid[2]), .out_bit(out_bit[2]), .busy(busy[2]),
        .gen_count(gen_count[2]), .stable(stable[2]), .extinct(extinct[2]), .state(state[2])
    );

    life_grid_engine #(.ROWS(4), .COLS(6), .WRAP(1), .GEN_W(8)) dut3 (
        .clock(clock), .reset(reset), .load_en(load_en[3]), .load_bit(load_bit[3]),
        .start(start[3]), .gen_target(gen_target[3]), .out_ready(out_ready[3]),
        .out_valid(out_valid[3]), .out_bit(out_bit[3]), .busy(busy[3]),
        .gen_count(gen_count[3]), .stable(stable[3]), .extinct(extinct[3]), .state(state[3])
    );

    function automatic int rowsOf(input int u);
        return (u < 2) ? 5 : 4;
    endfunction

    function automatic int colsOf(input int u);
        return (u < 2) ? 5 : 6;
    endfunction

    function automatic int wrapOf(input int u);
        return u % 2;
    endfunction

    // Reference generation step straight from the B3/S23 rule.
    function automatic bit [31:0] lifeStep(input int u, input bit [31:0] g);
        int rows = rowsOf(u);
        int cols = colsOf(u);
        int wrap = wrapOf(u);
        bit [31:0] nxt = '0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                int live = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr = r + dr;
                        int cc = c + dc;
                        if (dr == 0 && dc == 0) continue;
                        if (wrap != 0) begin
                            rr = (rr + rows) % rows;
                            cc = (cc + cols) % cols;
                        end else if (rr < 0 || rr >= rows || cc < 0 || cc >= cols) begin
                            continue;
                        end
                        live += int'(g[rr*cols+cc]);
                    end
                end
                nxt[r*cols+c] = (live == 3) || (g[r*cols+c] && (live == 2));
            end
        end
        return nxt;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic loadGrid(input int u, input bit [31:0] pattern);
        int n = rowsOf(u) * colsOf(u);
        for (int k = 0; k < n; k++) begin
            load_en[u]  = 1'b1;
            load_bit[u] = pattern[k];
            tick();
        end
        load_en[u]  = 1'b0;
        load_bit[u] = 1'b0;
    endtask

    // Loads (optionally), starts a run, consumes every dump and compares each
    // generation against the reference model; returns the last dump seen.
    task automatic applyStimulus(input int u, input bit [31:0] pattern, input logic [7:0] target,
                                 input bit stall, input bit noise, input bit do_load,
                                 input bit load_with_start, output bit [31:0] final_dump);
        int        n;
        int        idx;
        int        gens;
        int        cycles;
        bit [31:0] cur;
        bit [31:0] nxt;
        bit [31:0] dump;
        bit [31:0] exp_q[$];
        bit        exp_stable;
        bit        exp_extinct;
        bit        held_valid;
        bit        held_bit;
        bit        prev_valid;
        bit        rdy;

        n           = rowsOf(u) * colsOf(u);
        cur         = pattern;
        exp_stable  = 1'b0;
        exp_extinct = 1'b0;
        do begin
            nxt         = lifeStep(u, cur);
            exp_stable  = (nxt == cur);
            exp_extinct = (nxt == '0);
            exp_q.push_back(nxt);
            cur = nxt;
        end while (!(((target != 8'd0) && (exp_q.size() == int'(target))) ||
                     ((target == 8'd0) && (exp_stable || exp_extinct)) ||
                     (exp_q.size() == 255)));

        if (do_load) loadGrid(u, pattern);

        start[u]      = 1'b1;
        gen_target[u] = target;
        if (load_with_start) begin
            load_en[u]  = 1'b1;
            load_bit[u] = 1'b1;
        end
        tick();
        start[u]    = 1'b0;
        load_en[u]  = 1'b0;
        load_bit[u] = 1'b0;
        checkOutput("start_state", 32'(state[u]), 32'd1);
        checkOutput("start_busy", 32'(busy[u]), 32'd1);
        checkOutput("start_valid", 32'(out_valid[u]), 32'd0);

        idx        = 0;
        gens       = 0;
        cycles     = 1;
        dump       = '0;
        final_dump = '0;
        held_valid = 1'b0;
        held_bit   = 1'b0;
        prev_valid = 1'b0;
        while ((state[u] != 2'b00) && (cycles < RUN_BUDGET)) begin
            if (out_valid[u]) begin
                if (!prev_valid) checkOutput("gen_count_live", 32'(gen_count[u]), 32'(gens + 1));
                if (held_valid) checkOutput("hold_bit", 32'(out_bit[u]), 32'(held_bit));
                rdy          = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                out_ready[u] = rdy;
                if (rdy) begin
                    held_valid = 1'b0;
                    dump[idx]  = out_bit[u];
                    idx++;
                    if (idx == n) begin
                        if (gens < exp_q.size()) begin
                            checkOutput("gen_dump", dump, exp_q[gens]);
                        end else begin
                            checkOutput("gen_overrun", 32'(gens + 1), 32'(exp_q.size()));
                        end
                        final_dump = dump;
                        dump       = '0;
                        idx        = 0;
                        gens++;
                    end
                end else begin
                    held_valid = 1'b1;
                    held_bit   = out_bit[u];
                end
            end else begin
                held_valid   = 1'b0;
                out_ready[u] = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
            prev_valid = out_valid[u];
            if (noise) begin
                load_en[u]    = ($urandom_range(0, 1) == 1);
                load_bit[u]   = ($urandom_range(0, 1) == 1);
                start[u]      = ($urandom_range(0, 1) == 1);
                gen_target[u] = 8'($urandom_range(0, 255));
            end
            tick();
            cycles++;
        end
        out_ready[u]  = 1'b0;
        load_en[u]    = 1'b0;
        load_bit[u]   = 1'b0;
        start[u]      = 1'b0;
        gen_target[u] = 8'd0;

        checkOutput("idle_reached", 32'(state[u]), 32'd0);
        checkOutput("idle_busy", 32'(busy[u]), 32'd0);
        checkOutput("idle_valid", 32'(out_valid[u]), 32'd0);
        checkOutput("gen_total", 32'(gens), 32'(exp_q.size()));
        checkOutput("gen_count_final", 32'(gen_count[u]), 32'(exp_q.size()));
        checkOutput("stable_final", 32'(stable[u]), 32'(exp_stable));
        checkOutput("extinct_final", 32'(extinct[u]), 32'(exp_extinct));
        if (!stall) checkOutput("run_cycles", 32'(cycles - 1), 32'(exp_q.size() * (n + 1)));
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t      vecs[10];
        bit [31:0] fd;
        bit [31:0] mask;
        int        u;
        int        n;

        for (int i = 0; i < UNITS; i++) begin
            load_en[i]    = 1'b0;
            load_bit[i]   = 1'b0;
            start[i]      = 1'b0;
            gen_target[i] = 8'd0;
            out_ready[i]  = 1'b0;
        end

        vecs[0] = '{"blinker",       0, 32'h0002_1080, 8'd1,  1'b0, 1'b0, 32'h0000_3800, 8'd1,   1'b0, 1'b0};
        vecs[1] = '{"blinker_stall", 0, 32'h0002_1080, 8'd1,  1'b1, 1'b0, 32'h0000_3800, 8'd1,   1'b0, 1'b0};
        vecs[2] = '{"blinker_two",   0, 32'h0002_1080, 8'd2,  1'b0, 1'b0, 32'h0002_1080, 8'd2,   1'b0, 1'b0};
        vecs[3] = '{"block",         0, 32'h0000_18C0, 8'd0,  1'b0, 1'b1, 32'h0000_18C0, 8'd1,   1'b1, 1'b0};
        vecs[4] = '{"lone",          0, 32'h0000_1000, 8'd0,  1'b0, 1'b0, 32'h0000_0000, 8'd1,   1'b0, 1'b1};
        vecs[5] = '{"empty",         0, 32'h0000_0000, 8'd0,  1'b0, 1'b0, 32'h0000_0000, 8'd1,   1'b1, 1'b1};
        vecs[6] = '{"glider_torus",  1, 32'h0000_1C82, 8'd20, 1'b0, 1'b0, 32'h0000_1C82, 8'd20,  1'b0, 1'b0};
        vecs[7] = '{"corner_nowrap", 2, 32'h0004_0820, 8'd1,  1'b0, 1'b0, 32'h0000_0000, 8'd1,   1'b0, 1'b1};
        vecs[8] = '{"corner_wrap",   3, 32'h0004_0820, 8'd1,  1'b0, 1'b0, 32'h0000_0021, 8'd1,   1'b0, 1'b0};
        vecs[9] = '{"saturate",      0, 32'h0002_1080, 8'd0,  1'b0, 1'b0, 32'h0000_3800, 8'd255, 1'b0, 1'b0};

        tick();
        reset = 1'b0;
        for (int i = 0; i < UNITS; i++) begin
            checkOutput("reset_state", 32'(state[i]), 32'd0);
            checkOutput("reset_valid", 32'(out_valid[i]), 32'd0);
            checkOutput("reset_bit", 32'(out_bit[i]), 32'd0);
            checkOutput("reset_busy", 32'(busy[i]), 32'd0);
            checkOutput("reset_gen", 32'(gen_count[i]), 32'd0);
            checkOutput("reset_stable", 32'(stable[i]), 32'd0);
            checkOutput("reset_extinct", 32'(extinct[i]), 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].unit, vecs[i].init, vecs[i].target, vecs[i].stall, 1'b0,
                          1'b1, vecs[i].load_with_start, fd);
            checkOutput({vecs[i].name, "_dump"}, fd, vecs[i].exp_grid);
            checkOutput({vecs[i].name, "_gen"}, 32'(gen_count[vecs[i].unit]), 32'(vecs[i].exp_gen));
            checkOutput({vecs[i].name, "_stable"}, 32'(stable[vecs[i].unit]), 32'(vecs[i].exp_stable));
            checkOutput({vecs[i].name, "_extinct"}, 32'(extinct[vecs[i].unit]), 32'(vecs[i].exp_extinct));
            repeat (3) tick();
            checkOutput({vecs[i].name, "_idle_hold_gen"}, 32'(gen_count[vecs[i].unit]), 32'(vecs[i].exp_gen));
        end

        // Reset while bit 10 of a blinker dump is on offer.
        loadGrid(0, 32'h0002_1080);
        start[0]      = 1'b1;
        gen_target[0] = 8'd1;
        tick();
        start[0] = 1'b0;
        tick();
        out_ready[0] = 1'b1;
        repeat (10) tick();
        checkOutput("mid_dump_state", 32'(state[0]), 32'd2);
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        out_ready[0] = 1'b0;
        checkOutput("mid_reset_state", 32'(state[0]), 32'd0);
        checkOutput("mid_reset_valid", 32'(out_valid[0]), 32'd0);
        checkOutput("mid_reset_bit", 32'(out_bit[0]), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy[0]), 32'd0);
        checkOutput("mid_reset_gen", 32'(gen_count[0]), 32'd0);
        checkOutput("mid_reset_stable", 32'(stable[0]), 32'd0);
        checkOutput("mid_reset_extinct", 32'(extinct[0]), 32'd0);
        applyStimulus(0, 32'h0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, fd);
        checkOutput("post_reset_dump", fd, 32'h0);

        // Random patterns, random backpressure, and ignored control noise.
        for (int t = 0; t < 12; t++) begin
            u    = $urandom_range(0, 3);
            n    = rowsOf(u) * colsOf(u);
            mask = (32'd1 << n) - 32'd1;
            applyStimulus(u, $urandom & mask, 8'($urandom_range(1, 6)), 1'b1, 1'b1, 1'b1, 1'b0, fd);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
